fp_mul_iter: RTL
================

Name: fp_mul_iter

Overview:
- Iterative floating-point mantissa/exponent multiplier for the inverse-square-root datapath.
- Sits directly upstream of the multiply correction stage. Feeds that stage's valid, M_in_mul, E_in_mul and float_in_2 inputs.
- Operands are 31-bit sign-less floats: [30:23] biased exponent, [22:0] fraction.
- Produces the raw 48-bit significand product and the unbiased exponent sum. Normalisation and rounding are left to the correction stage.

Parameters:
- BITS_PER_CYCLE, 4, multiplier bits consumed per MUL cycle. Legal values: 1, 2, 3, 4, 6, 8, 12, 24. Any other value is a compile-time error.
- N_ITER, 24/BITS_PER_CYCLE, derived local constant. Not overridable.

Ports:
- clk  in  1  single clock; all flops are rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  start strobe. Sampled only when busy=0.
- float_in_a  in  31  operand A.
- float_in_b  in  31  operand B.
- float_in_2  in  31  side-band float, captured at start and passed through.
- M_out_mul  out  48  {1,A.frac} * {1,B.frac}. Connects to M_in_mul.
- E_out_mul  out  8 (signed)  (A.exp-127)+(B.exp-127). Connects to E_in_mul.
- float_out_2  out  31  float_in_2 captured at start. Connects to float_in_2 of the correction stage.
- ready  out  1  one-cycle result strobe. Connects to the correction stage's valid.
- busy  out  1  high while a multiply is in flight.

Behaviour:
- Reset is asynchronous, rst_n=0:
  - state=IDLE, accumulator=0, counter=0.
  - M_out_mul=0, E_out_mul=0, float_out_2=0, ready=0, busy=0.
- States: IDLE, MUL, DONE.
- busy=1 only in MUL. valid is accepted in IDLE or DONE.
- Accept edge T (busy=0 and valid=1):
  - Latch mcand={1,A[22:0]} and mplier={1,B[22:0]} (24 bits each).
  - Latch E_out_mul internal copy = A[30:23]+B[30:23]-254, computed in 8-bit two's complement, wrapping modulo 256, no saturation.
  - Latch float_in_2. Clear accumulator and counter. Go to MUL.
- MUL, one step per edge:
  - acc += mcand * mplier[BITS_PER_CYCLE-1:0], shifted left by BITS_PER_CYCLE*counter.
  - mplier >>= BITS_PER_CYCLE; counter++.
  - After N_ITER steps (edge T+N_ITER), go to DONE.
- Entering DONE (edge T+N_ITER+1):
  - M_out_mul, E_out_mul and float_out_2 update from the internal registers.
  - ready=1 for exactly this one cycle.
- Total latency from accept edge to ready-high: N_ITER+1 cycles. Default is 7.
- DONE lasts one cycle:
  - valid=1 in DONE starts a new operation (state goes to MUL, ready drops next edge).
  - Otherwise state goes to IDLE.
  - Back-to-back throughput is one result per N_ITER+1 cycles.
- Outputs hold their last values after ready falls, until the next DONE.
- valid while busy=1 is ignored. The operation is dropped silently, with no queueing and no effect on the in-flight result.
- Operand inputs change during MUL: no effect, because only the latched copies are used.
- Accumulator is 48 bits. The product of two 24-bit values with MSB set lies in [2^46, 2^48), so no overflow. Bit 47 set means the correction stage shifts.
- Reset asserted mid-MUL: the operation is aborted, no ready pulse, all outputs return to reset values.
- No sign handling: operand bit 31 does not exist in this datapath.

Optional Feature:
- Macro: FP_MUL_ZERO_DET_EN.
- Defined:
  - If A[30:23]==0 or B[30:23]==0 at accept, a zero flag is latched.
  - At DONE, M_out_mul=0 and E_out_mul=-127 (8'h81), so the correction stage emits float 0.
  - Latency and ready timing are unchanged, so ordering with float_out_2 is preserved.
- Undefined: exponent-0 operands are treated as normal values with an implicit leading 1. No flag logic is present.

Test Plan:
- 1.0*1.0, A=B=31'h3F800000: ready 7 cycles after accept; M_out_mul=48'h4000_0000_0000, E_out_mul=0, busy high for exactly 6 cycles.
- 1.5*1.5, A=B=31'h3FC00000, float_in_2=31'h12345678: M_out_mul=48'h9000_0000_0000 (bit47=1), E_out_mul=0, float_out_2=31'h12345678.
- 2.0*0.5, A=31'h40000000, B=31'h3F000000: M_out_mul=48'h4000_0000_0000, E_out_mul=0. Exponent extremes A.exp=B.exp=8'hFE: E_out_mul=8'hFE (wraps, 254 mod 256 read as -2), no saturation.
- valid pulsed during MUL with different operands: ignored; one ready only, carrying the first operation's result. Back-to-back valid held high: ready every 7 cycles.
- rst_n low at MUL step 3: outputs zero immediately (asynchronous), no ready after release, next valid produces a correct result.
- With FP_MUL_ZERO_DET_EN, A=31'h00000000, B=31'h3F800000: ready at 7 cycles, M_out_mul=0, E_out_mul=8'h81. Without the macro: M_out_mul=48'h4000_0000_0000, E_out_mul=8'h81.

Source files
------------

// File: rtl/fp_mul_iter.sv
// fp_mul_iter: iterative 24x24 significand multiplier with unbiased exponent sum, BITS_PER_CYCLE bits per step.
// Optional FP_MUL_ZERO_DET_EN forces a zero result when either operand exponent is 0.
module fp_mul_iter #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic [30:0]        float_in_a,
  input  logic [30:0]        float_in_b,
  input  logic [30:0]        float_in_2,
  output logic [47:0]        M_out_mul,
  output logic signed [7:0]  E_out_mul,
  output logic [30:0]        float_out_2,
  output logic               ready,
  output logic               busy
);
  localparam int N_ITER = 24 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N_ITER + 1);
  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 3 || BITS_PER_CYCLE == 4 ||
          BITS_PER_CYCLE == 6 || BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 12 || BITS_PER_CYCLE == 24)) begin : g_bad_bpc
      $error("fp_mul_iter: BITS_PER_CYCLE must divide 24 evenly");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nxt;
  logic [23:0] mcand, mplier;
  logic [47:0] acc, pp;
  logic [CW-1:0] cnt;
  logic [7:0] e_int;
  logic [30:0] f2_int;
  logic start, last;
`ifdef FP_MUL_ZERO_DET_EN
  logic zero;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    start = valid && state != MUL;
    last = state == MUL && cnt == CW'(N_ITER - 1);
    state_nxt = start ? MUL : state == MUL ? (last ? DONE : MUL) : IDLE;
  end
  always_comb busy = state == MUL;
  // partial product of the current multiplier digit, aligned to its weight
  always_comb pp = (48'(mcand) * 48'(mplier[BITS_PER_CYCLE-1:0])) << (BITS_PER_CYCLE * cnt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      e_int <= '0;
      f2_int <= '0;
      M_out_mul <= '0;
      E_out_mul <= '0;
      float_out_2 <= '0;
      ready <= 1'b0;
`ifdef FP_MUL_ZERO_DET_EN
      zero <= 1'b0;
`endif
    end else begin
      ready <= state == DONE;
      if (start) begin
        mcand <= {1'b1, float_in_a[22:0]};
        mplier <= {1'b1, float_in_b[22:0]};
        e_int <= float_in_a[30:23] + float_in_b[30:23] - 8'd254;
        f2_int <= float_in_2;
        acc <= '0;
        cnt <= '0;
`ifdef FP_MUL_ZERO_DET_EN
        zero <= float_in_a[30:23] == 8'd0 || float_in_b[30:23] == 8'd0;
`endif
      end else if (state == MUL) begin
        acc <= acc + pp;
        mplier <= mplier >> BITS_PER_CYCLE;
        cnt <= cnt + 1'b1;
      end
      if (state == DONE) begin
`ifdef FP_MUL_ZERO_DET_EN
        M_out_mul <= zero ? '0 : acc;
        E_out_mul <= zero ? 8'h81 : e_int;
`else
        M_out_mul <= acc;
        E_out_mul <= e_int;
`endif
        float_out_2 <= f2_int;
      end
    end
endmodule
